// File: rtl/pl_sysref_gen_if.sv
// Configuration, control and status bundle of the PL SYSREF generator.
interface pl_sysref_gen_if #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
);
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [NUM_W-1:0] cfg_count;
  logic             start;
  logic             stop;
  logic             pl_sysref_out;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [NUM_W-1:0] pulses_sent;

  modport master (
    output cfg_period, cfg_high, cfg_count, start, stop,
    input  pl_sysref_out, busy, done, cfg_err, pulses_sent
  );

  modport slave (
    input  cfg_period, cfg_high, cfg_count, start, stop,
    output pl_sysref_out, busy, done, cfg_err, pulses_sent
  );
endinterface

// File: rtl/pl_sysref_gen.sv
// Programmable SYSREF pulse-train generator: one-shot bursts, continuous runs,
// graceful stop that always completes the current period.
module pl_sysref_gen #(
  parameter int CNT_W     = 16,
  parameter int NUM_W     = 8,
  parameter int ARM_DELAY = 4
) (
  input  logic            pl_clk_buf,
  input  logic            pl_rst,
  pl_sysref_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic [NUM_W-1:0] count_q;
  logic [NUM_W-1:0] pulses;
  logic             stop_pend;
  logic             sysref_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             cfg_legal;
  logic             accept;
  logic             last_period;
  logic [NUM_W-1:0] pulses_inc;

  assign cfg_legal   = (bus.cfg_period >= CNT_W'(2)) && (bus.cfg_high != '0) &&
                       (bus.cfg_high < bus.cfg_period);
  assign accept      = (state == IDLE) && bus.start && cfg_legal;
  assign pulses_inc  = pulses + NUM_W'(1);
  // A stop seen on the closing LOW cycle ends the run at the same edge as a pending one.
  assign last_period = ((count_q != '0) && (pulses_inc == count_q)) || stop_pend || bus.stop;

  always_ff @(posedge pl_clk_buf) begin
    if (accept) begin
      period_q <= bus.cfg_period;
      high_q   <= bus.cfg_high;
      count_q  <= bus.cfg_count;
    end
  end

  always_ff @(posedge pl_clk_buf or posedge pl_rst) begin
    if (pl_rst) begin
      state     <= IDLE;
      phase     <= '0;
      pulses    <= '0;
      stop_pend <= 1'b0;
      sysref_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (cfg_legal) begin
              state     <= ARM;
              phase     <= CNT_W'(ARM_DELAY);
              pulses    <= '0;
              stop_pend <= 1'b0;
              err_q     <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ARM: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (phase == '0) begin
            state    <= HIGH;
            sysref_q <= 1'b1;
            phase    <= high_q - CNT_W'(1);
          end else begin
            phase <= phase - CNT_W'(1);
          end
        end
        HIGH: begin
          if (bus.stop) stop_pend <= 1'b1;
          if (phase == '0) begin
            state    <= LOW;
            sysref_q <= 1'b0;
            phase    <= period_q - high_q - CNT_W'(1);
          end else begin
            phase <= phase - CNT_W'(1);
          end
        end
        LOW: begin
          if (bus.stop) stop_pend <= 1'b1;
          if (phase == '0) begin
            pulses <= pulses_inc;
            if (last_period) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state    <= HIGH;
              sysref_q <= 1'b1;
              phase    <= high_q - CNT_W'(1);
            end
          end else begin
            phase <= phase - CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          sysref_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pl_sysref_out = sysref_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cfg_err       = err_q;
  assign bus.pulses_sent   = pulses;

endmodule

// File: tb/tb_pl_sysref_gen.sv
// Directed self-checking bench for pl_sysref_gen with hand-derived cycle expectations.
module tb_pl_sysref_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pl_sysref_gen_if #(.CNT_W(16), .NUM_W(8)) bus ();

  pl_sysref_gen #(.CNT_W(16), .NUM_W(8), .ARM_DELAY(4)) dut (
    .pl_clk_buf (clk),
    .pl_rst     (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int p, input int h, input int n);
    bus.cfg_period = 16'(p);
    bus.cfg_high   = 16'(h);
    bus.cfg_count  = 8'(n);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(8, 2, 3);
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.pl_sysref_out, bus.busy, bus.done, bus.cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.pl_sysref_out, bus.busy, bus.done, bus.cfg_err});
    end
    checks++;
    if (bus.pulses_sent !== 8'd0) begin
      errors++;
      $display("FAIL reset_pulses got=%0d exp=0", bus.pulses_sent);
    end
    rst = 1'b0;
    tick();
  endtask

  // period 8, high 2, count 3: high on 5-6, 13-14, 21-22; done at 29
  task automatic test_basic_burst(input string tag);
    logic eo, eb, ed;
    set_cfg(8, 2, 3);
    do_start();
    for (int c = 0; c <= 31; c++) begin
      eo = (c >= 5 && c <= 6) || (c >= 13 && c <= 14) || (c >= 21 && c <= 22);
      eb = (c <= 28);
      ed = (c == 29);
      checks++;
      if (bus.pl_sysref_out !== eo) begin
        errors++;
        $display("FAIL %s out cyc=%0d got=%b exp=%b", tag, c, bus.pl_sysref_out, eo);
      end
      checks++;
      if (bus.busy !== eb) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, c, bus.busy, eb);
      end
      checks++;
      if (bus.done !== ed) begin
        errors++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, c, bus.done, ed);
      end
      if (c == 0 || c == 29) begin
        checks++;
        if (bus.pulses_sent !== ((c == 0) ? 8'd0 : 8'd3)) begin
          errors++;
          $display("FAIL %s pulses cyc=%0d got=%0d", tag, c, bus.pulses_sent);
        end
      end
      tick();
    end
  endtask

  // period 2, high 1, continuous; stop during cycle 20 ends after that period
  task automatic test_continuous_stop();
    logic eo, eb, ed;
    set_cfg(2, 1, 0);
    do_start();
    for (int c = 0; c <= 23; c++) begin
      eo = (c >= 5) && (c <= 19) && (c % 2 == 1);
      eb = (c <= 20);
      ed = (c == 21);
      checks++;
      if (bus.pl_sysref_out !== eo) begin
        errors++;
        $display("FAIL cont_out cyc=%0d got=%b exp=%b", c, bus.pl_sysref_out, eo);
      end
      checks++;
      if ({bus.busy, bus.done} !== {eb, ed}) begin
        errors++;
        $display("FAIL cont_busy_done cyc=%0d got=%b%b exp=%b%b", c, bus.busy, bus.done, eb, ed);
      end
      if (c == 21) begin
        checks++;
        if (bus.pulses_sent !== 8'd8) begin
          errors++;
          $display("FAIL cont_pulses got=%0d exp=8", bus.pulses_sent);
        end
      end
      bus.stop = (c == 20);
      tick();
    end
    bus.stop = 1'b0;
  endtask

  // stop in the first HIGH cycle must not truncate the high time
  task automatic test_stop_in_high();
    logic eo, eb, ed;
    set_cfg(8, 2, 0);
    do_start();
    for (int c = 0; c <= 15; c++) begin
      eo = (c == 5) || (c == 6);
      eb = (c <= 12);
      ed = (c == 13);
      checks++;
      if ({bus.pl_sysref_out, bus.busy, bus.done} !== {eo, eb, ed}) begin
        errors++;
        $display("FAIL stophigh cyc=%0d got=%b%b%b exp=%b%b%b", c,
                 bus.pl_sysref_out, bus.busy, bus.done, eo, eb, ed);
      end
      if (c == 13) begin
        checks++;
        if (bus.pulses_sent !== 8'd1) begin
          errors++;
          $display("FAIL stophigh_pulses got=%0d exp=1", bus.pulses_sent);
        end
      end
      bus.stop = (c == 5);
      tick();
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_cfg_err();
    set_cfg(8, 8, 1);
    do_start();
    for (int c = 0; c <= 3; c++) begin
      checks++;
      if ({bus.cfg_err, bus.busy, bus.pl_sysref_out} !== 3'b100) begin
        errors++;
        $display("FAIL cfgerr_hi_eq_per cyc=%0d got=%b exp=100", c,
                 {bus.cfg_err, bus.busy, bus.pl_sysref_out});
      end
      tick();
    end
    set_cfg(8, 0, 1);
    do_start();
    checks++;
    if ({bus.cfg_err, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL cfgerr_hi_zero got=%b exp=10", {bus.cfg_err, bus.busy});
    end
    set_cfg(1, 1, 1);
    do_start();
    checks++;
    if ({bus.cfg_err, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL cfgerr_per_one got=%b exp=10", {bus.cfg_err, bus.busy});
    end
    set_cfg(4, 1, 1);
    do_start();
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin
        checks++;
        if (bus.cfg_err !== 1'b0) begin
          errors++;
          $display("FAIL cfgerr_clear got=%b exp=0", bus.cfg_err);
        end
      end
      checks++;
      if ({bus.pl_sysref_out, bus.busy, bus.done} !== {(c == 5), (c <= 8), (c == 9)}) begin
        errors++;
        $display("FAIL cfgerr_legal cyc=%0d got=%b%b%b", c,
                 bus.pl_sysref_out, bus.busy, bus.done);
      end
      tick();
    end
  endtask

  task automatic test_stop_in_arm();
    set_cfg(8, 2, 3);
    do_start();
    for (int c = 0; c <= 6; c++) begin
      checks++;
      if ({bus.pl_sysref_out, bus.busy, bus.done} !== {1'b0, (c <= 2), (c == 3)}) begin
        errors++;
        $display("FAIL stoparm cyc=%0d got=%b%b%b", c,
                 bus.pl_sysref_out, bus.busy, bus.done);
      end
      if (c == 3) begin
        checks++;
        if (bus.pulses_sent !== 8'd0) begin
          errors++;
          $display("FAIL stoparm_pulses got=%0d exp=0", bus.pulses_sent);
        end
      end
      bus.stop = (c == 2);
      tick();
    end
    bus.stop = 1'b0;
  endtask

  task automatic test_reset_mid_high();
    set_cfg(8, 2, 3);
    do_start();
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if ({bus.pl_sysref_out, bus.busy} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre got=%b exp=11", {bus.pl_sysref_out, bus.busy});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.pl_sysref_out, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async got=%b exp=000", {bus.pl_sysref_out, bus.busy, bus.done});
    end
    tick();
    checks++;
    if ({bus.pl_sysref_out, bus.busy, bus.pulses_sent} !== {2'b00, 8'd0}) begin
      errors++;
      $display("FAIL midrst_hold got=%b%b/%0d exp=00/0",
               bus.pl_sysref_out, bus.busy, bus.pulses_sent);
    end
    rst = 1'b0;
    tick();
    test_basic_burst("after_rst");
  endtask

  // period 4, high 1, continuous for 1100+ periods with ignored start/cfg changes
  task automatic test_wrap();
    logic eo;
    set_cfg(4, 1, 0);
    do_start();
    for (int c = 0; c <= 4410; c++) begin
      eo = (c >= 5) && (c <= 4408) && ((c - 5) % 4 == 0);
      checks++;
      if (bus.pl_sysref_out !== eo) begin
        errors++;
        $display("FAIL wrap_out cyc=%0d got=%b exp=%b", c, bus.pl_sysref_out, eo);
      end
      if (c == 4408 || c == 4409) begin
        checks++;
        if ({bus.busy, bus.done} !== {(c == 4408), (c == 4409)}) begin
          errors++;
          $display("FAIL wrap_end cyc=%0d got=%b%b", c, bus.busy, bus.done);
        end
      end
      if (c == 1028 || c == 1029 || c == 4405 || c == 4409) begin
        checks++;
        if (bus.pulses_sent !== ((c == 1028) ? 8'd255 : (c == 1029) ? 8'd0 :
                                 (c == 4405) ? 8'd76 : 8'd77)) begin
          errors++;
          $display("FAIL wrap_pulses cyc=%0d got=%0d", c, bus.pulses_sent);
        end
      end
      bus.start = (c == 600) || (c == 2000);
      if (c == 600) set_cfg(8, 3, 5);
      bus.stop = (c == 4405);
      tick();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_burst("burst");
    test_continuous_stop();
    test_stop_in_high();
    test_cfg_err();
    test_stop_in_arm();
    test_reset_mid_high();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
